// File: rtl/neokeon_theta_pi1_stage.sv
// Neokeon-128 encryption round stage ahead of Gamma: round-constant XOR, Theta, Pi1.
// Owns the RC LFSR and round counter and registers one result behind a valid/ready handshake.
module neokeon_theta_pi1_stage #(
  parameter int unsigned NROUNDS = 16,
  parameter logic [7:0]  RC_INIT = 8'h80
) (
  input  logic         inClk,
  input  logic         inRst,
  input  logic         inValid,
  output logic         outReadyUp,
  input  logic         inFirst,
  input  logic [127:0] inDataState,
  input  logic [127:0] inDataKey,
  output logic         outValid,
  input  logic         inReadyDown,
  output logic [127:0] outDataState,
  output logic [4:0]   outRound,
  output logic         outLast,
  output logic [7:0]   outRc
);

  localparam int unsigned WW = 32;
  localparam int unsigned SW = 128;
  localparam int unsigned RW = 5;
  localparam int unsigned CW = 8;

  function automatic logic [WW-1:0] rotl(input logic [WW-1:0] x, input int unsigned n);
    return (x << n) | (x >> (WW - n));
  endfunction

  function automatic logic [WW-1:0] rotr(input logic [WW-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WW - n));
  endfunction

  function automatic logic [WW-1:0] mix(input logic [WW-1:0] t);
    return t ^ rotr(t, 8) ^ rotl(t, 8);
  endfunction

  function automatic logic [CW-1:0] xtime(input logic [CW-1:0] c);
    return {c[CW-2:0], 1'b0} ^ (c[CW-1] ? 8'h1B : 8'h00);
  endfunction

  // RC XOR, Theta with the working key, then Pi1 unless this is the final pass
  function automatic logic [SW-1:0] round_fn(input logic [SW-1:0] st, input logic [SW-1:0] key,
                                             input logic [CW-1:0] rc, input logic do_pi1);
    logic [WW-1:0] a0, a1, a2, a3, t;
    a0 = st[127:96] ^ {24'b0, rc};
    a1 = st[95:64];
    a2 = st[63:32];
    a3 = st[31:0];
    t  = mix(a0 ^ a2);
    a1 = a1 ^ t ^ key[95:64];
    a3 = a3 ^ t ^ key[31:0];
    a0 = a0 ^ key[127:96];
    a2 = a2 ^ key[63:32];
    t  = mix(a1 ^ a3);
    a0 = a0 ^ t;
    a2 = a2 ^ t;
    if (do_pi1) begin
      a1 = rotl(a1, 1);
      a2 = rotl(a2, 5);
      a3 = rotl(a3, 2);
    end
    return {a0, a1, a2, a3};
  endfunction

  logic          valid_q, valid_d;
  logic [SW-1:0] data_q, data_d;
  logic [RW-1:0] round_q, round_d;
  logic [CW-1:0] rc_q, rc_d;
  logic          last_q, last_d;
  logic [CW-1:0] rc_reg_q, rc_reg_d;
  logic [RW-1:0] round_cnt_q, round_cnt_d;

  logic          accept;
  logic [CW-1:0] rc_sel;
  logic [RW-1:0] r_sel;
  logic          is_final;

  assign outReadyUp = !valid_q || inReadyDown;
  assign accept     = inValid && outReadyUp;
  assign rc_sel     = inFirst ? RC_INIT : rc_reg_q;
  assign r_sel      = inFirst ? '0 : round_cnt_q;
  assign is_final   = (r_sel == RW'(NROUNDS));

  // Next-state: load on accept, otherwise drop valid when downstream takes the result
  always_comb begin
    valid_d     = valid_q;
    data_d      = data_q;
    round_d     = round_q;
    rc_d        = rc_q;
    last_d      = last_q;
    rc_reg_d    = rc_reg_q;
    round_cnt_d = round_cnt_q;
    if (accept) begin
      valid_d = 1'b1;
      data_d  = round_fn(inDataState, inDataKey, rc_sel, !is_final);
      round_d = r_sel;
      rc_d    = rc_sel;
      last_d  = is_final;
      if (is_final) begin
        rc_reg_d    = RC_INIT;
        round_cnt_d = '0;
      end else begin
        rc_reg_d    = xtime(rc_sel);
        round_cnt_d = r_sel + RW'(1);
      end
    end else if (valid_q && inReadyDown) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge inClk) begin
    if (inRst) begin
      valid_q     <= 1'b0;
      data_q      <= '0;
      round_q     <= '0;
      rc_q        <= '0;
      last_q      <= 1'b0;
      rc_reg_q    <= RC_INIT;
      round_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      data_q      <= data_d;
      round_q     <= round_d;
      rc_q        <= rc_d;
      last_q      <= last_d;
      rc_reg_q    <= rc_reg_d;
      round_cnt_q <= round_cnt_d;
    end
  end

  assign outValid     = valid_q;
  assign outDataState = data_q;
  assign outRound     = round_q;
  assign outLast      = last_q;
  assign outRc        = rc_q;

endmodule
